restador_arbiter: RTL and testbench

//  Round-robin arbiter sharing one registered subtractor core between NREQ requesters.

---
 rtl/restador_pkg.sv | 16 +
 rtl/subtractor_core.sv | 35 +++
 rtl/restador_arbiter.sv | 117 +++++++++++
 tb/tb_restador_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/restador_pkg.sv
// restador_pkg: shared types and default sizing for the restador arbiter.
//   state_t    - arbiter FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   DEF_WIDTH  - default operand/result width
//   DEF_NREQ   - default number of requesters
package restador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 3;

endpackage

// File: rtl/subtractor_core.sv
// subtractor_core: registered unsigned subtractor.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset, clears y and borrow
//   en     in  load enable; y/borrow update only when set
//   a, b   in  minuend / subtrahend
//   y      out a - b mod 2^WIDTH (registered, holds between loads)
//   borrow out 1 when a < b unsigned (registered, holds between loads)
module subtractor_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             borrow
);

  logic [WIDTH:0] diff_d;

  // Widen by one bit so the MSB of the difference is the borrow-out.
  assign diff_d = {1'b0, a} - {1'b0, b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y      <= '0;
      borrow <= 1'b0;
    end else if (en) begin
      y      <= diff_d[WIDTH-1:0];
      borrow <= diff_d[WIDTH];
    end
  end

endmodule

// File: rtl/restador_arbiter.sv
// restador_arbiter: round-robin arbiter in front of one shared subtractor core.
//   clk     in  rising-edge clock
//   reset   in  asynchronous active-high reset
//   req     in  per-requester request level
//   a_flat  in  minuend bus, requester i at [i*WIDTH +: WIDTH]
//   b_flat  in  subtrahend bus, same packing
//   gnt     out one-hot grant, held for the whole operation
//   done    out one-cycle pulse, y/borrow valid for the gnt owner
//   y       out last result a - b mod 2^WIDTH
//   borrow  out last borrow (a < b unsigned)
//   busy    out high whenever the FSM is not idle
module restador_arbiter
  import restador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_flat,
  input  logic [NREQ*WIDTH-1:0] b_flat,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic [WIDTH-1:0]      y,
  output logic                  borrow,
  output logic                  busy
);

  // Pointer/index width; kept at least 1 bit so NREQ=1 still elaborates.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    win_q;
  logic [PW-1:0]    win_d;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  onehot_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             done_q;
  logic             busy_q;
  logic             core_en;
  int               idx;

  // Round-robin pick: scan downward from the farthest offset so the last
  // hit, i.e. the one closest to ptr_q, is the one that sticks.
  always_comb begin
    win_d = '0;
    idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (req[idx]) win_d = PW'(idx);
    end
  end

  always_comb begin
    onehot_d        = '0;
    onehot_d[win_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            // Operands are captured here so later bus changes cannot
            // disturb the in-flight operation.
            a_q     <= a_flat[int'(win_d)*WIDTH +: WIDTH];
            b_q     <= b_flat[int'(win_d)*WIDTH +: WIDTH];
            win_q   <= win_d;
            gnt_q   <= onehot_d;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= PW'((int'(win_q) + 1) % NREQ);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_en = (state_q == CALC);

  subtractor_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .en    (core_en),
    .a     (a_q),
    .b     (b_q),
    .y     (y),
    .borrow(borrow)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_restador_arbiter.sv
module tb_restador_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_flat, b_flat;
  logic [NREQ-1:0]       gnt;
  logic                  done, borrow, busy;
  logic [WIDTH-1:0]      y;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;   // reference round-robin pointer

  always #5 clk = ~clk;

  restador_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .done(done), .y(y), .borrow(borrow), .busy(busy)
  );

  // Reference model: first set request at or after the pointer, cyclically.
  function automatic int exp_win(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  // Reference model: {borrow, y} from plain integer arithmetic.
  function automatic logic [WIDTH:0] exp_sub(input int a, input int b);
    logic [WIDTH:0] r;
    int m;
    m = 1 << WIDTH;
    r[WIDTH]     = (a < b);
    r[WIDTH-1:0] = WIDTH'(((a - b) % m + m) % m);
    return r;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic set_ops(input int i, input int a, input int b);
    a_flat[i*WIDTH +: WIDTH] = WIDTH'(a);
    b_flat[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; a_flat = '0; b_flat = '0;
    #1;
    checks++;
    if ({gnt, done, busy, y, borrow} !== '0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b done=%b busy=%b y=%h borrow=%b, want all 0", gnt, done, busy, y, borrow);
    end
    @(negedge clk); reset = 1'b0; m_ptr = 0;
    @(negedge clk);
    checks++;
    if ({gnt, busy} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got gnt=%b busy=%b, want 0", gnt, busy);
    end
  endtask

  task automatic test_single;
    set_ops(0, 15, 1); req = 3'b001;
    @(negedge clk);
    checks++;
    if ({gnt, busy, done} !== {3'b001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b busy=%b done=%b, want 001 1 0", gnt, busy, done);
    end
    @(negedge clk);
    checks++;
    if ({done, borrow, y, gnt} !== {1'b1, 1'b0, 4'd14, 3'b001}) begin
      errors++;
      $display("FAIL single_done: got done=%b borrow=%b y=%0d gnt=%b, want 1 0 14 001", done, borrow, y, gnt);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({done, gnt, busy, y} !== {1'b0, 3'b000, 1'b0, 4'd14}) begin
      errors++;
      $display("FAIL single_release: got done=%b gnt=%b busy=%b y=%0d, want 0 000 0 14", done, gnt, busy, y);
    end
    m_ptr = 1;
  endtask

  task automatic test_wrap;
    int av[2] = '{0, 10};
    int bv[2] = '{1, 5};
    logic [WIDTH:0] ev[2] = '{{1'b1, 4'd15}, {1'b0, 4'd5}};
    for (int k = 0; k < 2; k++) begin
      set_ops(0, av[k], bv[k]); req = 3'b001;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({done, borrow, y} !== {1'b1, ev[k]}) begin
        errors++;
        $display("FAIL wrap_%0d: got done=%b borrow=%b y=%0d, want 1 %b %0d", k, done, borrow, y, ev[k][WIDTH], ev[k][WIDTH-1:0]);
      end
      req = '0;
      @(negedge clk);
    end
    m_ptr = 1;
  endtask

  task automatic test_pointer;
    // serve req0 first so the pointer moves to 1
    set_ops(0, 3, 3); set_ops(2, 8, 1); req = 3'b001;
    @(negedge clk); @(negedge clk); req = '0; @(negedge clk);
    req = 3'b101;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b100) begin
      errors++;
      $display("FAIL pointer_first: got gnt=%b, want 100", gnt);
    end
    @(negedge clk);
    checks++;
    if ({done, y} !== {1'b1, 4'd7}) begin
      errors++;
      $display("FAIL pointer_first_res: got done=%b y=%0d, want 1 7", done, y);
    end
    req = 3'b001;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL pointer_second: got gnt=%b, want 001", gnt);
    end
    @(negedge clk); req = '0; @(negedge clk);
    m_ptr = 1;
  endtask

  task automatic test_latch;
    set_ops(1, 9, 3); req = 3'b010;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("FAIL latch_grant: got gnt=%b, want 010", gnt);
    end
    set_ops(1, 0, 3); req = '0;
    @(negedge clk);
    checks++;
    if ({done, borrow, y, gnt} !== {1'b1, 1'b0, 4'd6, 3'b010}) begin
      errors++;
      $display("FAIL latch_result: got done=%b borrow=%b y=%0d gnt=%b, want 1 0 6 010", done, borrow, y, gnt);
    end
    @(negedge clk);
    m_ptr = 2;
  endtask

  task automatic test_reset_mid;
    set_ops(1, 7, 2); req = 3'b010;
    @(negedge clk);
    checks++;
    if ({gnt, busy} !== {3'b010, 1'b1}) begin
      errors++;
      $display("FAIL rmid_grant: got gnt=%b busy=%b, want 010 1", gnt, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, done, busy, y, borrow} !== '0) begin
      errors++;
      $display("FAIL rmid_clear: got gnt=%b done=%b busy=%b y=%0d borrow=%b, want all 0", gnt, done, busy, y, borrow);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_no_done: got done=%b, want 0", done);
    end
    reset = 1'b0; m_ptr = 0;
    set_ops(1, 12, 4); req = 3'b010;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("FAIL rmid_regrant: got gnt=%b, want 010", gnt);
    end
    @(negedge clk);
    checks++;
    if ({done, borrow, y} !== {1'b1, 1'b0, 4'd8}) begin
      errors++;
      $display("FAIL rmid_result: got done=%b borrow=%b y=%0d, want 1 0 8", done, borrow, y);
    end
    req = '0;
    @(negedge clk);
    m_ptr = 2;
  endtask

  task automatic test_fairness;
    logic [NREQ-1:0] order[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset = 1'b1; req = '0;
    @(negedge clk); reset = 1'b0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 4 + i, i);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== order[k]) begin
        errors++;
        $display("FAIL fair_gnt_%0d: got gnt=%b, want %b", k, gnt, order[k]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL fair_done_%0d: got done=%b, want 1", k, done);
      end
      @(negedge clk);
      checks++;
      if ({done, gnt} !== '0) begin
        errors++;
        $display("FAIL fair_gap_%0d: got done=%b gnt=%b, want 0 000", k, done, gnt);
      end
    end
    req = '0;
    @(negedge clk);
    m_ptr = 1;
  endtask

  task automatic test_random;
    logic [NREQ-1:0] r;
    logic [WIDTH:0]  e;
    int w, ea, eb;
    for (int it = 0; it < 80; it++) begin
      r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      a_flat = ($urandom); b_flat = ($urandom);
      req = r;
      if (r == '0) begin
        @(negedge clk);
        checks++;
        if ({gnt, busy, done} !== '0) begin
          errors++;
          $display("FAIL rand_idle_%0d: got gnt=%b busy=%b done=%b, want 0", it, gnt, busy, done);
        end
      end else begin
        w  = exp_win(r, m_ptr);
        ea = int'(a_flat[w*WIDTH +: WIDTH]);
        eb = int'(b_flat[w*WIDTH +: WIDTH]);
        e  = exp_sub(ea, eb);
        @(negedge clk);
        checks++;
        if ({gnt, busy} !== {onehot(w), 1'b1}) begin
          errors++;
          $display("FAIL rand_gnt_%0d: got gnt=%b busy=%b, want %b 1", it, gnt, busy, onehot(w));
        end
        // scramble everything while the op is in flight
        a_flat = ($urandom); b_flat = ($urandom); req = NREQ'($urandom);
        @(negedge clk);
        checks++;
        if ({done, borrow, y} !== {1'b1, e}) begin
          errors++;
          $display("FAIL rand_res_%0d: got done=%b borrow=%b y=%0d, want 1 %b %0d (a=%0d b=%0d)", it, done, borrow, y, e[WIDTH], e[WIDTH-1:0], ea, eb);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if ({done, gnt, busy} !== '0) begin
          errors++;
          $display("FAIL rand_end_%0d: got done=%b gnt=%b busy=%b, want 0", it, done, gnt, busy);
        end
        m_ptr = (w + 1) % NREQ;
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_pointer;
    test_latch;
    test_reset_mid;
    test_fairness;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
